// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port data RAM.
// Each grant becomes one RAM access cycle; read data returns registered with an rvalid pulse.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module dmem_arbiter #(
    parameter int ADDR_W = `ADDRESS_SIZE,
    parameter int DATA_W = `DATA_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [DATA_W-1:0] ram_write_data,
    output logic [ADDR_W-1:0] ram_read_address,
    input  logic [DATA_W-1:0] ram_read_data
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]        state;
    logic              last_grant;
    logic              owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              sel_valid;
    logic              sel_id;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        sel_valid = req0 | req1;
        sel_id    = (req0 & req1) ? ~last_grant : req1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata      <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state      <= ACCESS;
                        owner      <= sel_id;
                        last_grant <= sel_id;
                        we_q       <= sel_id ? we1    : we0;
                        addr_q     <= sel_id ? addr1  : addr0;
                        wdata_q    <= sel_id ? wdata1 : wdata0;
                        gnt0       <= ~sel_id;
                        gnt1       <= sel_id;
                    end
                end
                ACCESS: begin
                    state <= IDLE;
                    if (!we_q) begin
                        rdata   <= ram_read_data;
                        rvalid0 <= ~owner;
                        rvalid1 <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write enable is gated by state so the RAM only ever sees a write in ACCESS.
    assign busy              = (state == ACCESS);
    assign ram_write_enable  = busy & we_q;
    assign ram_write_address = addr_q;
    assign ram_read_address  = addr_q;
    assign ram_write_data    = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, transaction-level reference model, per-cycle compare.
module tb_dmem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_we;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_waddr, ram_raddr;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy),
        .ram_write_enable(ram_we), .ram_write_address(ram_waddr),
        .ram_write_data(ram_wdata), .ram_read_address(ram_raddr),
        .ram_read_data(ram_rdata)
    );

    always #5 clk = ~clk;

    // Data RAM driven by the DUT.
    logic [DW-1:0] ram [256];
    assign ram_rdata = ram[ram_raddr];
    always @(posedge clk) if (ram_we) ram[ram_waddr] <= ram_wdata;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: one in-flight command slot, a memory image and the expected outputs.
    logic [DW-1:0] mmem [256];
    bit            cur_v = 0, cur_owner = 0, cur_we = 0, m_last = 1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    bit            m_g0 = 0, m_g1 = 0, m_rv0 = 0, m_rv1 = 0;

    initial for (int i = 0; i < 256; i++) begin ram[i] = '0; mmem[i] = '0; end

    always @(posedge clk) begin
        bit pick;
        m_g0 = 0; m_g1 = 0; m_rv0 = 0; m_rv1 = 0;
        if (reset) begin
            if (cur_v && cur_we) mmem[m_addr] = m_wdata;
            cur_v = 0; cur_we = 0; cur_owner = 0; m_last = 1;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (cur_v) begin
            if (cur_we) mmem[m_addr] = m_wdata;
            else begin
                m_rdata = mmem[m_addr];
                if (cur_owner) m_rv1 = 1; else m_rv0 = 1;
            end
            cur_v = 0;
        end else if (req0 || req1) begin
            pick = (req0 && req1) ? !m_last : req1;
            cur_v = 1; cur_owner = pick; m_last = pick;
            cur_we  = pick ? we1 : we0;
            m_addr  = pick ? addr1 : addr0;
            m_wdata = pick ? wdata1 : wdata0;
            if (pick) m_g1 = 1; else m_g0 = 1;
        end
    end

    // Per-cycle compare plus an event log for the literal checks.
    int            gq[$];
    logic [DW-1:0] rv0q[$], rv1q[$];
    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt0", gnt0, m_g0);
            chk("gnt1", gnt1, m_g1);
            chk("rvalid0", rvalid0, m_rv0);
            chk("rvalid1", rvalid1, m_rv1);
            chk("busy", busy, cur_v);
            chk("ram_we", ram_we, cur_v && cur_we);
            chk("ram_waddr", ram_waddr, m_addr);
            chk("ram_raddr", ram_raddr, m_addr);
            chk("ram_wdata", ram_wdata, m_wdata);
            chk("rdata", rdata, m_rdata);
            if (gnt0) gq.push_back(0);
            if (gnt1) gq.push_back(1);
            if (rvalid0) rv0q.push_back(rdata);
            if (rvalid1) rv1q.push_back(rdata);
        end
    end

    // Raise req with its command and hold it until the grant is seen; lat = cycles to gnt.
    task automatic do_req(input int r, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat);
        bit got;
        lat = 0; got = 0;
        if (r == 0) begin we0 = w; addr0 = a; wdata0 = d; req0 = 1; end
        else        begin we1 = w; addr1 = a; wdata1 = d; req1 = 1; end
        while (!got && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
            got = (r == 0) ? gnt0 : gnt1;
        end
        if (r == 0) req0 = 0; else req1 = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL grant_timeout req%0d: no gnt after %0d cycles, required within 20", r, lat);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int la, lb, n;
    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1;
        reset = 0;

        // Idle after reset: nothing may fire.
        idle(5);
        chk("idle_no_grants", gq.size(), 0);

        // Write then read back through requester 0.
        do_req(0, 1, 8'h10, 32'hDEADBEEF, la);
        chk("wr_gnt_latency", la, 1);
        idle(1);
        do_req(0, 0, 8'h10, 32'h0, la);
        chk("rd_gnt_latency", la, 1);
        idle(1);
        chk("rd_rvalid0", rvalid0, 1'b1);
        chk("rd_rdata", rdata, 32'hDEADBEEF);

        // Loader preloads 0x10/0x20, then both requesters contend continuously.
        do_req(1, 1, 8'h10, 32'h11, la);
        idle(1);
        do_req(1, 1, 8'h20, 32'h22, la);
        idle(1);
        gq.delete(); rv0q.delete(); rv1q.delete();
        fork
            begin do_req(0, 0, 8'h10, 0, la); do_req(0, 0, 8'h10, 0, la); end
            begin do_req(1, 0, 8'h20, 0, lb); do_req(1, 0, 8'h20, 0, lb); end
        join
        idle(3);
        chk("rr_count", gq.size(), 4);
        if (gq.size() == 4) begin
            chk("rr_order0", gq[0], 0);
            chk("rr_order1", gq[1], 1);
            chk("rr_order2", gq[2], 0);
            chk("rr_order3", gq[3], 1);
        end
        chk("rv0_count", rv0q.size(), 2);
        chk("rv1_count", rv1q.size(), 2);
        foreach (rv0q[i]) chk("rv0_data", rv0q[i], 32'h11);
        foreach (rv1q[i]) chk("rv1_data", rv1q[i], 32'h22);

        // Same-cycle write (req1) and read (req0) of 0x3: req0 wins, sees old data.
        rv0q.delete();
        fork
            do_req(1, 1, 8'h03, 32'h5, la);
            do_req(0, 0, 8'h03, 32'h0, lb);
        join
        chk("b2b_rd_lat", lb, 1);
        chk("b2b_wr_lat", la, 3);
        idle(2);
        chk("b2b_rv0_count", rv0q.size(), 1);
        if (rv0q.size() > 0) chk("b2b_prewrite", rv0q[0], 32'h0);
        do_req(0, 0, 8'h03, 32'h0, la);
        idle(2);
        chk("b2b_rv0_count2", rv0q.size(), 2);
        if (rv0q.size() > 1) chk("b2b_postwrite", rv0q[1], 32'h5);

        // Reset during a req1 read ACCESS cancels the response.
        n = rv1q.size();
        do_req(1, 0, 8'h20, 32'h0, la);
        reset = 1;
        @(posedge clk); @(negedge clk);
        reset = 0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        idle(3);
        chk("rst_no_rv1", rv1q.size(), n);
        do_req(1, 0, 8'h20, 32'h0, la);
        chk("post_rst_lat", la, 1);
        idle(2);
        chk("post_rst_rv1", rv1q.size(), n + 1);
        if (rv1q.size() > n) chk("post_rst_data", rv1q[n], 32'h22);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port data RAM (one write port, one read port, one shared address space).
- Requester 0 is the pipeline MEM stage. Requester 1 is the test/debug loader.
- Each accepted command is serialised into one RAM access cycle. Read data is returned as a registered response with a valid pulse.
- The arbiter drives every RAM control input to a known value after reset, so the RAM never sees X/Z on write_enable.

Parameters:
- ADDR_W, `ADDRESS_SIZE: address width of requester and RAM ports.
- DATA_W, `DATA_SIZE: data width of requester and RAM ports.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1 each  access request; held with command fields stable until the matching gnt.
- we0, we1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  ADDR_W each  access address.
- wdata0, wdata1  in  DATA_W each  write data; ignored for reads.
- gnt0, gnt1  out  1 each  one-cycle pulse; the command was consumed.
- rvalid0, rvalid1  out  1 each  one-cycle pulse; rdata holds that requester's read result.
- rdata  out  DATA_W  registered read data, shared by both requesters.
- busy  out  1  high while in ACCESS.
- ram_write_enable  out  1  RAM write enable.
- ram_write_address  out  ADDR_W  RAM write address.
- ram_write_data  out  DATA_W  RAM write data.
- ram_read_address  out  ADDR_W  RAM read address.
- ram_read_data  in  DATA_W  RAM read data, combinational from ram_read_address.

Behaviour:
- FSM states: IDLE and ACCESS. Reset state is IDLE.
- Values while reset is sampled high:
  - gnt*, rvalid*, busy and ram_write_enable are 0.
  - rdata, ram_write_address, ram_write_data and ram_read_address are 0.
  - last_grant is 1, so requester 0 wins the first tie.
- Arbitration in IDLE at a posedge:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, select that requester.
  - If both are high, select the requester that is not last_grant.
- On selection:
  - Latch we, addr and wdata into the RAM-side registers.
  - Go to ACCESS and pulse gnt of the selected requester for that cycle.
  - Update last_grant to the selected requester.
- ACCESS cycle:
  - busy = 1.
  - ram_write_address and ram_read_address both equal the latched address.
  - ram_write_enable equals the latched we.
  - The RAM write commits at the posedge ending ACCESS.
  - For a read, rdata <= ram_read_data at that posedge and rvalid of the owner pulses in the following cycle.
  - Next state is always IDLE.
- Outside ACCESS, ram_write_enable = 0. Address and data registers hold their last values.
- Timing:
  - Latency from req sampled to gnt is 1 cycle.
  - Latency from req sampled to rvalid is 2 cycles.
  - Maximum throughput is one access per 2 cycles.
  - The rvalid cycle overlaps IDLE, so a new req can be sampled at the same edge that ends rvalid.
- rdata holds its value until the next read completes. Writes never change rdata.
- A requester must not drop req before gnt. If req drops while in ACCESS, the already-latched command still completes.
- Reset sampled during ACCESS:
  - A write whose ram_write_enable is high at that edge still commits, because the RAM samples it.
  - A pending read produces no rvalid.
  - All outputs take their reset values from the next cycle.
- Widths: no arithmetic is performed. Addresses and data pass through unmodified at ADDR_W / DATA_W.

Test Plan:
- Reset, then idle 5 cycles -> ram_write_enable, busy, gnt* and rvalid* remain 0; no X on any output.
- req0 writes 0xDEADBEEF to address 0x10, then req0 reads 0x10 -> gnt0 one cycle after each req is sampled; rvalid0 two cycles after the read req is sampled; rdata = 0xDEADBEEF.
- req0 and req1 both held high as reads of 0x10 and 0x20 (preloaded with 0x11 and 0x22) -> grant order 0, 1, 0, 1; rvalid0 always carries 0x11 and rvalid1 always carries 0x22; gnt0 and gnt1 are never high in the same cycle.
- Back-to-back: req1 writes 0x5 to address 0x3 while req0 reads address 0x3 in the same cycle -> req0 is granted first and returns pre-write data; after req1's write commits, a repeated req0 read of 0x3 returns 0x5.
- Reset asserted in ACCESS of a read for req1 -> no rvalid1 pulse; FSM in IDLE in the next cycle; the next req1 is granted normally.
